demux32_fifo: RTL
=================

Name: demux32_fifo

Overview:
- 1-to-2 registered demultiplexer for 32-bit datapath words; inverse of the 2:1 word select.
- One producer stream is steered by a per-word select bit to one of two consumer streams, each behind a small FIFO.
- Sits between the execute/write-back stage and two downstream sinks, e.g. the register-file write port and the memory store path.
- Decouples producer and consumer stalls with valid/ready handshakes on all three ports.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 2, entries per output FIFO; power of two, minimum 2
CNTW, 2, width of the per-output occupancy counters; must hold 0..DEPTH

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer word valid
in_ready  output  1  block can accept the word on in_data this cycle
in_data  input  WIDTH  producer word
in_sel  input  1  destination: 0 steers to port A, 1 steers to port B
a_valid  output  1  FIFO A head valid
a_ready  input  1  consumer A accepts head
a_data  output  WIDTH  FIFO A head word
b_valid  output  1  FIFO B head valid
b_ready  input  1  consumer B accepts head
b_data  output  WIDTH  FIFO B head word
a_count  output  CNTW  FIFO A occupancy
b_count  output  CNTW  FIFO B occupancy

Behaviour:
- Reset:
  - rst high clears both FIFOs immediately, with no clock required.
  - Cleared state: pointers 0, a_count=b_count=0, a_valid=b_valid=0, a_data=b_data=0.
  - Storage contents are don't-care after reset, but data outputs read 0 while their FIFO is empty.
  - A reset mid-transfer discards all buffered words; no partial state survives.
- Input handshake:
  - Transfer occurs when in_valid & in_ready at the clock edge.
  - in_ready = (in_sel ? b_count : a_count) != DEPTH.
  - in_ready depends only on in_sel and registered occupancy; no combinational path from a_ready or b_ready.
  - A word offered to a full FIFO stalls, even if that FIFO drains in the same cycle.
  - The producer must hold in_data and in_sel stable while in_valid is high and in_ready is low.
- Output handshake:
  - x_valid = (x_count != 0).
  - x_data = word at the FIFO x read pointer.
  - Dequeue occurs on x_valid & x_ready.
  - x_valid and x_data are driven from registered state only.
- Latency:
  - An accepted word appears on x_valid/x_data on the cycle after the accepting edge.
  - Minimum latency is 1 cycle; there is no fall-through.
- Ordering:
  - Each output preserves input order for the words steered to it.
  - No ordering is defined between A and B.
- Occupancy, per FIFO:
  - Enqueue only: count+1.
  - Dequeue only: count-1.
  - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
  - Neither: hold.
  - Simultaneous enqueue/dequeue on a FIFO holding 1 word: head advances to the new word; x_valid stays 1.
- Pointers:
  - log2(DEPTH)-bit read and write pointers, wrapping modulo DEPTH.
  - Full and empty are distinguished by count, not by pointer comparison.
- Boundary conditions:
  - x_ready asserted while the FIFO is empty is ignored; count does not underflow.
  - in_valid low: no state change on the input side, whatever in_sel is.
  - A full, B empty, in_sel=1: the word is accepted into B; A's back-pressure does not block B.
  - X on in_sel while in_valid is low must not corrupt state.

Test Plan:
- Reset and basic steer:
  - Stimulus: assert rst mid-cycle, release; then send 0xDEADBEEF with in_sel=0, a_ready=1.
  - Required: a_valid=0 and a_count=0 immediately on rst; after release, a_valid=1 with a_data=0xDEADBEEF one cycle after acceptance; b_valid stays 0.
- Fill and stall:
  - Stimulus: a_ready=0; send 0x1, 0x2, 0x3 to A.
  - Required: first two accepted, a_count=2, in_ready=0 while 0x3 is offered. Then raise a_ready: 0x1 and 0x2 exit in order; 0x3 is accepted the cycle after count drops to 1.
- Independence:
  - Stimulus: A full with a_ready=0; send 0x55AA55AA with in_sel=1, b_ready=1.
  - Required: accepted immediately, b_data=0x55AA55AA next cycle, A contents untouched.
- Simultaneous enqueue/dequeue:
  - Stimulus: B holds 1 word (0x10); same cycle enqueue 0x20 to B with b_ready=1.
  - Required: b_count stays 1, next head is 0x20, b_valid never drops.
- Wrap-around and interleave:
  - Stimulus: random 1000-word stream, random in_sel and random ready throttling.
  - Required: per-port output sequence equals the filtered input order; counts never exceed 2 or go below 0.
- Reset mid-operation:
  - Stimulus: both FIFOs full, pulse rst asynchronously between edges.
  - Required: counts 0 and valids 0 before the next edge; no stale word emerges afterwards.

Source files
------------

// File: rtl/demux32_fifo.sv
// 1-to-2 registered demultiplexer: a single producer stream is steered by in_sel
// into one of two small FIFOs, each with its own valid/ready consumer port.
module demux32_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNTW-1:0]  a_count,
  output logic [CNTW-1:0]  b_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Index 0 is FIFO A, index 1 is FIFO B.
  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] mem_d [2][DEPTH];
  logic [PW-1:0]    rd_q  [2];
  logic [PW-1:0]    rd_d  [2];
  logic [PW-1:0]    wr_q  [2];
  logic [PW-1:0]    wr_d  [2];
  logic [CNTW-1:0]  cnt_q [2];
  logic [CNTW-1:0]  cnt_d [2];

  logic [1:0] valid;
  logic [1:0] out_ready;
  logic [1:0] push;
  logic [1:0] pop;

  // Readiness looks only at registered occupancy, so a full FIFO stalls even if it drains this cycle.
  assign in_ready  = (in_sel ? cnt_q[1] : cnt_q[0]) != CNTW'(DEPTH);
  assign valid     = {cnt_q[1] != '0, cnt_q[0] != '0};
  assign out_ready = {b_ready, a_ready};
  assign push      = {in_valid & in_ready & in_sel, in_valid & in_ready & ~in_sel};
  assign pop       = valid & out_ready;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_d[i][wr_q[i]] = in_data;
        wr_d[i]           = wr_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rd_d[i] = rd_q[i] + PW'(1);
      end
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNTW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNTW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: outputs are gated to zero whenever a FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign a_valid = valid[0];
  assign b_valid = valid[1];
  assign a_data  = valid[0] ? mem_q[0][rd_q[0]] : '0;
  assign b_data  = valid[1] ? mem_q[1][rd_q[1]] : '0;
  assign a_count = cnt_q[0];
  assign b_count = cnt_q[1];

endmodule
